clk_div_multi: RTL and testbench

Parametrised multi-channel successor to the single fixed 1 kHz divider. Generates N_CH independent square-wave clock enables/strobes from the system clock, each with a run-time programmable half-period, per-channel enable and a global phase-align restart. Sits next to the top-level clock input and feeds scan, debounce and display-refresh logic; outputs are fabric signals, not global clocks.

---
 rtl/clk_div_multi.sv | 69 ++++++
 tb/tb_clk_div_multi.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - N_CH independent programmable square-wave dividers with tick strobes
module clk_div_multi #(
   parameter int N_CH = 4,
   parameter int CH_W = 2,
   parameter int WIDTH = 16,
   parameter logic [WIDTH-1:0] DEFAULT_HALF = 16'd50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   ch_en,
   input  logic              sync,
   input  logic              wr_en,
   input  logic [CH_W-1:0]   wr_ch,
   input  logic [WIDTH-1:0]  wr_half,
   output logic [N_CH-1:0]   clk_out,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   active
);

   logic [WIDTH-1:0] half [N_CH];
   logic [WIDTH-1:0] cnt  [N_CH];
   logic [N_CH-1:0]  wr_sel;

   // Out-of-range channel numbers match no channel and are thus ignored.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         wr_sel[i] = wr_en && (32'(wr_ch) == i);
      end
   end

   always_comb begin
      active = '0;
      for (int i = 0; i < N_CH; i++) begin
         active[i] = ch_en[i] && (half[i] != '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_out <= '0;
         tick    <= '0;
         for (int i = 0; i < N_CH; i++) begin
            half[i] <= DEFAULT_HALF;
            cnt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (wr_sel[i]) begin
               half[i] <= wr_half;
            end
            // Hold and restart share the same effect; restart beats a terminal-count toggle.
            if (!ch_en[i] || (half[i] == '0) || sync || wr_sel[i]) begin
               cnt[i]     <= '0;
               clk_out[i] <= 1'b0;
               tick[i]    <= 1'b0;
            end else if (cnt[i] == half[i] - 1'b1) begin
               cnt[i]     <= '0;
               clk_out[i] <= ~clk_out[i];
               tick[i]    <= ~clk_out[i];
            end else begin
               cnt[i]  <= cnt[i] + 1'b1;
               tick[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - scoreboard bench for clk_div_multi (4-channel and 3-channel builds)
module tb_clk_div_multi;

   localparam int DEF_HALF = 50000;

   typedef struct packed {
      logic [3:0] c;
      logic [3:0] t;
      logic [3:0] a;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [3:0]  ch_en;
   logic        sync;
   logic        wr_en;
   logic [1:0]  wr_ch;
   logic [15:0] wr_half;
   logic [3:0]  clk_out4, tick4, active4;
   logic [2:0]  clk_out3, tick3, active3;

   int   n_chk;
   int   n_pass;
   int   cyc;
   int   mh [4];
   int   k  [4];
   exp_t sb [$];

   clk_div_multi #(.N_CH(4), .CH_W(2), .WIDTH(16), .DEFAULT_HALF(16'd50000)) u_dut4 (
      .clk(clk), .reset(reset), .ch_en(ch_en), .sync(sync), .wr_en(wr_en),
      .wr_ch(wr_ch), .wr_half(wr_half), .clk_out(clk_out4), .tick(tick4), .active(active4)
   );

   clk_div_multi #(.N_CH(3), .CH_W(2), .WIDTH(16), .DEFAULT_HALF(16'd50000)) u_dut3 (
      .clk(clk), .reset(reset), .ch_en(ch_en[2:0]), .sync(sync), .wr_en(wr_en),
      .wr_ch(wr_ch), .wr_half(wr_half), .clk_out(clk_out3), .tick(tick3), .active(active3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Phase model: k = running edges since last restart; output derived arithmetically.
   task automatic model_edge(output exp_t e);
      logic hit;
      logic hold;
      e = '0;
      for (int i = 0; i < 4; i++) begin
         if (!reset) begin
            mh[i] = DEF_HALF;
            k[i]  = 0;
         end else begin
            hit  = wr_en && (int'(wr_ch) == i);
            hold = !ch_en[i] || (mh[i] == 0);
            if (hold || sync || hit) k[i] = 0;
            else k[i]++;
            if (hit) mh[i] = int'(wr_half);
         end
         if (mh[i] != 0) begin
            e.c[i] = ((k[i] / mh[i]) % 2) == 1;
            e.t[i] = (k[i] % (2 * mh[i])) == mh[i];
         end
         e.a[i] = ch_en[i] && (mh[i] != 0);
      end
   endtask

   task automatic cycle(input int n);
      exp_t e;
      for (int c = 0; c < n; c++) begin
         model_edge(e);
         sb.push_back(e);
         @(posedge clk);
         #1;
         cyc++;
         e = sb.pop_front();
         check($sformatf("clk_out4@%0d", cyc), 32'(clk_out4), 32'(e.c));
         check($sformatf("tick4@%0d", cyc),    32'(tick4),    32'(e.t));
         check($sformatf("active4@%0d", cyc),  32'(active4),  32'(e.a));
         check($sformatf("clk_out3@%0d", cyc), 32'(clk_out3), 32'(e.c[2:0]));
         check($sformatf("tick3@%0d", cyc),    32'(tick3),    32'(e.t[2:0]));
         check($sformatf("active3@%0d", cyc),  32'(active3),  32'(e.a[2:0]));
      end
   endtask

   task automatic write(input logic [1:0] ch, input logic [15:0] h);
      wr_en   = 1'b1;
      wr_ch   = ch;
      wr_half = h;
      cycle(1);
      wr_en   = 1'b0;
   endtask

   initial begin
      int rise;
      n_chk   = 0;
      n_pass  = 0;
      cyc     = 0;
      reset   = 1'b0;
      ch_en   = '0;
      sync    = 1'b0;
      wr_en   = 1'b0;
      wr_ch   = '0;
      wr_half = '0;
      for (int i = 0; i < 4; i++) begin
         mh[i] = DEF_HALF;
         k[i]  = 0;
      end
      cycle(3);
      reset = 1'b1;
      cycle(2);

      // Ch0 shortened to H=3
      ch_en = 4'b0001;
      write(2'd0, 16'd3);
      cycle(20);

      // Ch1 H=1 then H=0
      ch_en = 4'b0011;
      write(2'd1, 16'd1);
      cycle(8);
      write(2'd1, 16'd0);
      cycle(3);

      // Ch2 H=5, rewritten to 2 in the middle of the high phase
      ch_en = 4'b0111;
      write(2'd2, 16'd5);
      cycle(7);
      check("ch2_high_before_rewrite", 32'(clk_out4[2]), 32'd1);
      write(2'd2, 16'd2);
      cycle(10);

      // Ch3 H=3 started later than ch0, then aligned by sync on a ch0 terminal count
      write(2'd3, 16'd3);
      ch_en = 4'b1111;
      cycle(4);
      for (int j = 0; j < 6 && (k[0] % mh[0]) != mh[0] - 1; j++) cycle(1);
      sync = 1'b1;
      cycle(1);
      sync = 1'b0;
      cycle(10);

      // Channel 3 write: out of range on the 3-channel build
      write(2'd3, 16'd7);
      cycle(10);

      // Sync and write in the same cycle
      sync = 1'b1;
      write(2'd1, 16'd2);
      sync = 1'b0;
      cycle(12);

      // Asynchronous reset in mid-cycle while running
      #2;
      reset = 1'b0;
      #1;
      check("async_clk_out4", 32'(clk_out4), 32'd0);
      check("async_tick4",    32'(tick4),    32'd0);
      check("async_clk_out3", 32'(clk_out3), 32'd0);
      check("async_tick3",    32'(tick3),    32'd0);
      cycle(3);
      ch_en = 4'b0001;
      reset = 1'b1;

      // Default half-period restored: first rise 50000 edges after release
      rise = -1;
      for (int n = 1; n <= DEF_HALF + 100 && rise < 0; n++) begin
         cycle(1);
         if (clk_out4[0]) rise = n;
      end
      check("first_rise_default", 32'(rise), 32'(DEF_HALF));
      cycle(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
